// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply or restoring divide takes
// one bit per cycle. Divide-by-zero and signed overflow skip the iterations.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN+1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              neg;
  logic [CW-1:0]     cnt;
  // Multiply: {high, low} product. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc;

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, ovf, fast, accept;
  logic [XLEN-1:0] fast_res, a_in, b_in;

  assign is_div   = func3[2];
  assign a_sgn    = is_div ? !func3[0] : (func3[1:0] != 2'b11);
  assign b_sgn    = is_div ? !func3[0] : !func3[1];
  assign a_neg    = a_sgn & rs1[XLEN-1];
  assign b_neg    = b_sgn & rs2[XLEN-1];
  assign a_in     = a_neg ? -rs1 : rs1;
  assign b_in     = b_neg ? -rs2 : rs2;
  assign div_zero = is_div && (rs2 == '0);
  assign ovf      = is_div && !func3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign fast     = div_zero || ovf;
  assign fast_res = div_zero ? (func3[1] ? rs1 : '1) : (func3[1] ? '0 : rs1);
  assign accept   = (state == IDLE) && req_valid && !flush;

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, mul_full;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_abs} : {(XLEN+1){1'b0}});
  assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
  assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b_abs};
  assign div_nxt  = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign mul_full = neg ? -acc : acc;
  assign quot_fix = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res  = op[2] ? (op[1] ? rem_fix : quot_fix)
                          : ((op[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= '0;
      a_abs  <= '0;
      b_abs  <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op    <= func3;
          a_abs <= a_in;
          b_abs <= b_in;
          // REM follows the dividend; everything else is the xor of operand signs.
          neg   <= (is_div && func3[1]) ? a_neg : (a_neg ^ b_neg);
          cnt   <= CW'(XLEN);
          acc   <= {{XLEN{1'b0}}, (is_div ? a_in : b_in)};
          if (fast) result <= fast_res;
        end
        CALC: begin
          acc <= op[2] ? div_nxt : mul_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX: result <= fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised + directed bench for muldiv_seq with an arithmetic reference model
// and a queue-based scoreboard checked on every response handshake.
module tb_muldiv_seq;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic        req_ready, resp_valid, busy;
  logic [2:0]  func3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, result;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .func3(func3), .rs1(rs1), .rs2(rs2), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = (f != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = (f <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    case (f)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Scoreboard: compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else check("result", result, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    bit busy_ok;
    logic [31:0] r0;
    func3 = f; rs1 = a; rs2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(model(f, a, b));
    lat = 1;
    busy_ok = 1'b1;
    while (!resp_valid && lat < 200) begin
      busy_ok &= busy;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), is_fast(f, a, b) ? 32'd1 : 32'd34);
    check("busy_during_op", 32'(busy_ok & busy), 32'd1);
    repeat (hold) begin
      r0 = result;
      @(posedge clk); #1;
      check("hold_stable", result, r0);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_valid", 32'(resp_valid), 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("back_to_idle", 32'({resp_valid, req_ready, busy}), 32'b010);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, 32'd0);
  endtask

  initial begin
    bit seen;
    logic [2:0] f;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd9, 32'd0, 0);
    run_op(3'd7, 32'd9, 32'd0, 0);

    // Flush during CALC: operation discarded, no response ever appears.
    func3 = 3'd0; rs1 = 32'd1234; rs2 = 32'd5678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 32'({resp_valid, req_ready, busy}), 32'b010);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    check("flush_no_resp", 32'(seen), 32'd0);

    // Request presented together with flush is not taken.
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(f, a, b, $urandom_range(0, 2));
    end

    // Synchronous reset in the middle of an operation.
    func3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd5, 32'd100, 32'd7, 0);

    @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
